// File: rtl/conv_ctrl.sv
// Frame controller for a 3x3 convolution datapath: feeds pixels into the conv shift registers
// and tags which datapath outputs are full in-image windows, delayed to match conv latency.
module conv_ctrl #(
    parameter int unsigned IMG_W    = 5,
    parameter int unsigned IMG_H    = 5,
    parameter int unsigned CONV_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [7:0] in_pxl,
    output logic       in_ready,
    output logic       conv_clr,
    output logic       conv_en,
    output logic [7:0] conv_pxl,
    output logic       win_valid,
    output logic [7:0] win_row,
    output logic [7:0] win_col,
    output logic       busy,
    output logic       done
);
    localparam logic [7:0] ColLast   = 8'(IMG_W - 1);
    localparam logic [7:0] RowLast   = 8'(IMG_H - 1);
    localparam logic [2:0] DrainLast = 3'(CONV_LAT - 1);

    typedef enum logic [2:0] {StIdle, StFill, StRun, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [7:0]          col_q, col_d;
    logic [7:0]          row_q, row_d;
    logic [7:0]          pxl_q, pxl_d;
    logic [2:0]          drain_q, drain_d;
    logic [CONV_LAT-1:0] pv_q, pv_d;
    logic [7:0]          prow_q [CONV_LAT];
    logic [7:0]          prow_d [CONV_LAT];
    logic [7:0]          pcol_q [CONV_LAT];
    logic [7:0]          pcol_d [CONV_LAT];
    logic                accept, kill, last_col, last_row;

    always_comb begin
        in_ready = (state_q == StFill) || (state_q == StRun);
        kill     = abort && (state_q != StIdle);
        // abort wins over a pixel offered in the same cycle
        accept   = in_valid && in_ready && !abort;
        last_col = (col_q == ColLast);
        last_row = (row_q == RowLast);

        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        drain_d  = drain_q;
        pxl_d    = accept ? in_pxl : pxl_q;
        conv_clr = 1'b0;

        if (accept) begin
            col_d = last_col ? 8'd0 : col_q + 8'd1;
            if (last_col) begin
                row_d = last_row ? 8'd0 : row_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d  = StFill;
                    col_d    = 8'd0;
                    row_d    = 8'd0;
                    conv_clr = 1'b1;
                end
            end
            StFill: begin
                if (accept && (row_q == 8'd1) && last_col) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept && last_row && last_col) begin
                    state_d = StDrain;
                    drain_d = 3'd0;
                end
            end
            StDrain: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (kill) begin
            state_d = StIdle;
        end

        // Window tag pipeline: shifts every cycle, zeros fill bubbles, abort flushes it.
        pv_d = '0;
        for (int i = 0; i < int'(CONV_LAT); i++) begin
            prow_d[i] = 8'd0;
            pcol_d[i] = 8'd0;
        end
        if (!kill) begin
            pv_d[0] = accept && (row_q >= 8'd2) && (col_q >= 8'd2);
            if (pv_d[0]) begin
                prow_d[0] = row_q - 8'd1;
                pcol_d[0] = col_q - 8'd1;
            end
            for (int i = 1; i < int'(CONV_LAT); i++) begin
                pv_d[i]   = pv_q[i-1];
                prow_d[i] = prow_q[i-1];
                pcol_d[i] = pcol_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            pxl_q   <= 8'd0;
            drain_q <= 3'd0;
            pv_q    <= '0;
            for (int i = 0; i < int'(CONV_LAT); i++) begin
                prow_q[i] <= 8'd0;
                pcol_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pxl_q   <= pxl_d;
            drain_q <= drain_d;
            pv_q    <= pv_d;
            for (int i = 0; i < int'(CONV_LAT); i++) begin
                prow_q[i] <= prow_d[i];
                pcol_q[i] <= pcol_d[i];
            end
        end
    end

    assign conv_en   = accept;
    assign conv_pxl  = pxl_d;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign win_valid = pv_q[CONV_LAT-1];
    assign win_row   = prow_q[CONV_LAT-1];
    assign win_col   = pcol_q[CONV_LAT-1];

endmodule
